// File: rtl/pool_1d_max.sv
// Streaming 1-D max-pooling stage: reduces each non-overlapping window of P signed words
// to its maximum, emitting N/P words per frame and discarding the N mod P trailing words.
module pool_1d_max #(
    parameter int unsigned N = 29,
    parameter int unsigned P = 2,
    parameter int unsigned W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] x_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic signed [W-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                y_last
);

    localparam int unsigned M     = N / P;
    localparam int unsigned R     = N - M * P;
    localparam int unsigned WinW  = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned OutW  = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned TailW = (R > 0) ? $clog2(R + 1) : 1;

    typedef enum logic [1:0] {
        StFirst,
        StAcc,
        StTail
    } state_e;

    state_e              state_q, state_d;
    logic signed [W-1:0] max_r_q, max_r_d;
    logic [WinW-1:0]     win_cnt_q, win_cnt_d;
    logic [OutW-1:0]     out_cnt_q, out_cnt_d;
    logic [TailW-1:0]    tail_cnt_q, tail_cnt_d;
    logic signed [W-1:0] y_data_q, y_data_d;
    logic                y_valid_q, y_valid_d;
    logic                y_last_q, y_last_d;

    logic                in_fire;
    logic                out_fire;
    logic                emit;
    logic                frame_end;
    logic signed [W-1:0] emit_val;
    logic signed [W-1:0] cand;
    logic [TailW-1:0]    tail_inc;

    // The output register is the only buffer, so input stalls whenever it is full and held.
    assign x_ready  = reset & (~y_valid_q | y_ready);
    assign in_fire  = x_valid & x_ready;
    assign out_fire = y_valid_q & y_ready;

    assign y_data  = y_data_q;
    assign y_valid = y_valid_q;
    assign y_last  = y_last_q;

    always_comb begin
        state_d    = state_q;
        max_r_d    = max_r_q;
        win_cnt_d  = win_cnt_q;
        out_cnt_d  = out_cnt_q;
        tail_cnt_d = tail_cnt_q;
        y_data_d   = y_data_q;
        y_valid_d  = y_valid_q;
        y_last_d   = y_last_q;
        emit       = 1'b0;
        emit_val   = max_r_q;
        frame_end  = 1'b0;
        cand       = (x_data > max_r_q) ? x_data : max_r_q;
        tail_inc   = tail_cnt_q + TailW'(1);

        if (in_fire) begin
            unique case (state_q)
                StFirst: begin
                    max_r_d = x_data;
                    if (P == 1) begin
                        emit     = 1'b1;
                        emit_val = x_data;
                    end else begin
                        win_cnt_d = WinW'(1);
                        state_d   = StAcc;
                    end
                end
                StAcc: begin
                    if (win_cnt_q == WinW'(P - 1)) begin
                        emit      = 1'b1;
                        emit_val  = cand;
                        win_cnt_d = '0;
                    end else begin
                        max_r_d   = cand;
                        win_cnt_d = win_cnt_q + WinW'(1);
                    end
                end
                StTail: begin
                    if (tail_inc == TailW'(R)) begin
                        tail_cnt_d = '0;
                        state_d    = StFirst;
                    end else begin
                        tail_cnt_d = tail_inc;
                    end
                end
                default: state_d = StFirst;
            endcase
        end

        // An emit wins over the clear, so a simultaneous transfer keeps y_valid high.
        if (emit) begin
            frame_end = (out_cnt_q == OutW'(M - 1));
            y_data_d  = emit_val;
            y_valid_d = 1'b1;
            y_last_d  = frame_end;
            out_cnt_d = frame_end ? '0 : out_cnt_q + OutW'(1);
            state_d   = (frame_end && (R > 0)) ? StTail : StFirst;
        end else if (out_fire) begin
            y_valid_d = 1'b0;
            y_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StFirst;
            max_r_q    <= '0;
            win_cnt_q  <= '0;
            out_cnt_q  <= '0;
            tail_cnt_q <= '0;
            y_data_q   <= '0;
            y_valid_q  <= 1'b0;
            y_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            max_r_q    <= max_r_d;
            win_cnt_q  <= win_cnt_d;
            out_cnt_q  <= out_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            y_data_q   <= y_data_d;
            y_valid_q  <= y_valid_d;
            y_last_q   <= y_last_d;
        end
    end

endmodule

// File: tb/tb_pool_1d_max.sv
// Bench for pool_1d_max: P=2, P=1 and P=4 instances share stimulus; a queue-based scoreboard
// is filled by a reference model as words are accepted and drained by a negedge monitor.
module tb_pool_1d_max;

    localparam int N = 29;
    localparam int W = 16;

    typedef logic signed [W-1:0] word_t;
    typedef struct {
        word_t data;
        logic  last;
    } exp_t;
    typedef struct {
        word_t a;
        word_t b;
        word_t expv;
    } pair_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    word_t x_data = '0;
    logic  x_valid = 1'b0;
    logic  y_ready = 1'b0;
    int    sel = 2;

    logic  xv1, xr1, yv1, yl1;
    logic  xv2, xr2, yv2, yl2;
    logic  xv4, xr4, yv4, yl4;
    word_t yd1, yd2, yd4;
    logic  xr_m, yv_m, yl_m;
    word_t yd_m;

    assign xv1 = x_valid && (sel == 1);
    assign xv2 = x_valid && (sel == 2);
    assign xv4 = x_valid && (sel == 4);

    pool_1d_max #(.N(N), .P(1), .W(W)) u_p1 (
        .clk(clk), .reset(reset), .x_data(x_data), .x_valid(xv1), .x_ready(xr1),
        .y_data(yd1), .y_valid(yv1), .y_ready(y_ready), .y_last(yl1)
    );
    pool_1d_max #(.N(N), .P(2), .W(W)) u_p2 (
        .clk(clk), .reset(reset), .x_data(x_data), .x_valid(xv2), .x_ready(xr2),
        .y_data(yd2), .y_valid(yv2), .y_ready(y_ready), .y_last(yl2)
    );
    pool_1d_max #(.N(N), .P(4), .W(W)) u_p4 (
        .clk(clk), .reset(reset), .x_data(x_data), .x_valid(xv4), .x_ready(xr4),
        .y_data(yd4), .y_valid(yv4), .y_ready(y_ready), .y_last(yl4)
    );

    always_comb begin
        xr_m = xr2;
        yv_m = yv2;
        yd_m = yd2;
        yl_m = yl2;
        case (sel)
            1: begin xr_m = xr1; yv_m = yv1; yd_m = yd1; yl_m = yl1; end
            4: begin xr_m = xr4; yv_m = yv4; yd_m = yd4; yl_m = yl4; end
            default: ;
        endcase
    end

    initial forever #5 clk = ~clk;

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t  q[$];
    exp_t  mon_e;
    word_t frame[64];
    pair_t tbl[3];
    int    vec = 0;
    int    bad = 0;
    int    n_out = 0;
    int    n_last = 0;
    int    stalls = 0;
    int    prev_cyc = 0;
    int    gap_exp = 2;
    bit    chk_gap = 0;
    bit    seen = 0;

    task automatic check(input string name, input int got, input int expv);
        vec++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Monitor: a transfer seen here completes at the following rising edge.
    always @(negedge clk) begin
        if (reset && yv_m && y_ready) begin
            n_out++;
            if (yl_m) n_last++;
            vec++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got data=%0d last=%0b, none expected", yd_m, yl_m);
            end else begin
                mon_e = q.pop_front();
                if (yd_m !== mon_e.data || yl_m !== mon_e.last) begin
                    bad++;
                    $display("FAIL output_%0d: got data=%0d last=%0b, expected data=%0d last=%0b",
                             n_out, yd_m, yl_m, mon_e.data, mon_e.last);
                end
            end
            if (chk_gap && seen) begin
                vec++;
                if (cyc - prev_cyc != gap_exp) begin
                    bad++;
                    $display("FAIL output_gap: got %0d cycles, expected %0d", cyc - prev_cyc, gap_exp);
                end
            end
            seen = 1;
            prev_cyc = cyc;
        end
    end

    task automatic start_test();
        n_out = 0;
        n_last = 0;
        stalls = 0;
        seen = 0;
    endtask

    // Drives frame[base+first .. base+stop-1]; pushes the model's window max when a closing
    // word is accepted, except for windows below skip_w whose results were pushed by the caller.
    task automatic send_frame(input int pk, input int base, input int first, input int stop,
                              input int skip_w);
        int    m;
        bit    acc;
        word_t mx;
        m = N / pk;
        for (int i = first; i < stop; i++) begin
            x_data  = frame[base + i];
            x_valid = 1'b1;
            acc     = 0;
            for (int t = 0; t < 300 && !acc; t++) begin
                @(negedge clk);
                if (xr_m) begin
                    acc = 1;
                    if (i < m * pk && (i % pk) == pk - 1 && (i / pk) >= skip_w) begin
                        mx = frame[base + i - pk + 1];
                        for (int j = i - pk + 2; j <= i; j++)
                            if (frame[base + j] > mx) mx = frame[base + j];
                        q.push_back('{data: mx, last: ((i / pk) == m - 1)});
                    end
                end else begin
                    stalls++;
                end
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                vec++;
                bad++;
                $display("FAIL accept_timeout: word %0d not accepted, expected acceptance", i);
                x_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain(input string name, input int exp_n, input int exp_last);
        for (int t = 0; t < 400 && q.size() != 0; t++) @(negedge clk);
        repeat (6) @(negedge clk);
        check({name, "_pending"}, q.size(), 0);
        check({name, "_count"}, n_out, exp_n);
        check({name, "_lasts"}, n_last, exp_last);
        @(posedge clk);
        #1;
    endtask

    initial begin
        word_t bp_exp;
        bit    done;

        tbl[0] = '{a: word_t'(-5),     b: word_t'(-7), expv: word_t'(-5)};
        tbl[1] = '{a: word_t'(-32768), b: word_t'(0),  expv: word_t'(0)};
        tbl[2] = '{a: word_t'(7),      b: word_t'(7),  expv: word_t'(7)};

        y_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y_valid", yv_m, 0);
        check("reset_y_last", yl_m, 0);
        check("reset_y_data", yd_m, 0);
        check("reset_x_ready", xr_m, 0);
        reset = 1'b1;
        #1;
        check("release_x_ready", xr_m, 1);
        @(posedge clk);
        #1;

        // Ramp: 3,9,...,81 with last on 81, word 84 dropped, no input stall.
        start_test();
        chk_gap = 1;
        gap_exp = 2;
        for (int i = 0; i < N; i++) frame[i] = word_t'(3 * i);
        send_frame(2, 0, 0, N, 0);
        x_valid = 1'b0;
        drain("ramp", 14, 1);
        check("ramp_stalls", stalls, 0);
        chk_gap = 0;

        // Signed compare from the table, rest of the frame negative filler.
        start_test();
        for (int k = 0; k < 3; k++) begin
            frame[2 * k]     = tbl[k].a;
            frame[2 * k + 1] = tbl[k].b;
            q.push_back('{data: tbl[k].expv, last: 1'b0});
        end
        for (int i = 6; i < N; i++) frame[i] = word_t'(i - 20);
        send_frame(2, 0, 0, N, 3);
        x_valid = 1'b0;
        drain("signed", 14, 1);

        // Backpressure from the first emit for 10 cycles.
        start_test();
        for (int i = 0; i < N; i++) frame[i] = word_t'($urandom);
        bp_exp = (frame[1] > frame[0]) ? frame[1] : frame[0];
        fork
            begin
                send_frame(2, 0, 0, N, 0);
                x_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 50 && !yv_m; t++) begin
                    @(posedge clk);
                    #1;
                end
                y_ready = 1'b0;
                check("bp_first_emit", yv_m, 1);
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    vec++;
                    if (xr_m !== 1'b0 || yv_m !== 1'b1 || yd_m !== bp_exp) begin
                        bad++;
                        $display("FAIL bp_hold_%0d: got x_ready=%0b y_valid=%0b y_data=%0d, expected 0 1 %0d",
                                 k, xr_m, yv_m, yd_m, bp_exp);
                    end
                end
                @(posedge clk);
                #1;
                y_ready = 1'b1;
            end
        join
        drain("backpressure", 14, 1);

        // Two back-to-back frames with random y_ready.
        start_test();
        for (int i = 0; i < 2 * N; i++) frame[i] = word_t'($urandom);
        done = 0;
        fork
            begin
                send_frame(2, 0, 0, N, 0);
                send_frame(2, N, 0, N, 0);
                x_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    y_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        y_ready = 1'b1;
        drain("b2b", 28, 2);

        // Reset with an output pending: it must vanish, then a fresh frame runs cleanly.
        start_test();
        for (int i = 0; i < N; i++) frame[i] = word_t'($urandom);
        send_frame(2, 0, 0, 7, 0);
        y_ready = 1'b0;
        send_frame(2, 0, 7, 8, 0);
        x_data  = frame[8];
        x_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_pending_valid", yv_m, 1);
            check("rst_pending_xready", xr_m, 0);
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        reset   = 1'b0;
        #1;
        check("rst_y_valid", yv_m, 0);
        check("rst_x_ready", xr_m, 0);
        check("rst_consumed", n_out, 3);
        check("rst_discarded", q.size(), 1);
        q.delete();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        y_ready = 1'b1;
        start_test();
        for (int i = 0; i < N; i++) frame[i] = word_t'($urandom);
        send_frame(2, 0, 0, N, 0);
        x_valid = 1'b0;
        drain("post_reset", 14, 1);

        // P=1 echoes every word; P=4 gives 7 outputs and drops word 28.
        sel = 1;
        start_test();
        chk_gap = 1;
        gap_exp = 1;
        for (int i = 0; i < N; i++) frame[i] = word_t'($urandom);
        send_frame(1, 0, 0, N, 0);
        x_valid = 1'b0;
        drain("p1", 29, 1);
        check("p1_stalls", stalls, 0);

        sel = 4;
        start_test();
        gap_exp = 4;
        for (int i = 0; i < N; i++) frame[i] = word_t'($urandom);
        send_frame(4, 0, 0, N, 0);
        x_valid = 1'b0;
        drain("p4", 7, 1);
        check("p4_stalls", stalls, 0);
        chk_gap = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
